sevenseg_scan_driver: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 24 ++
 rtl/sevenseg_scan_driver_hex_to_seg7.sv | 14 +
 rtl/sevenseg_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM encoding,
// hex-to-segment table (active-low cathodes {g,f,e,d,c,b,a}) and idle levels.
package sevenseg_pkg;

    // state  | meaning
    // S_OFF  | scan disabled, display dark, counters parked at 0
    // S_LOAD | one-cycle capture of HEX_IN/DP_IN into the shadow registers
    // S_SCAN | cycling through digit slots, reloading shadow at frame end
    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    // Inactive anode level; replicated to the digit count by the users.
    localparam logic       AN_OFF  = 1'b1;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sevenseg_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-low segment pattern decoder.
module hex_to_seg7
    import sevenseg_pkg::*;
(
    input  logic [3:0] NIBBLE,
    output logic [6:0] SEG_N
);

    // Pure table lookup; registering happens in the scan driver.
    always_comb begin
        SEG_N = SEG_TABLE[NIBBLE];
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver. The displayed value is held
// in a shadow register reloaded only at frame boundaries so a frame never
// mixes old and new digits. Each digit slot starts with BLANK_CYC dark cycles
// to hide ghosting while the anode switches.
//
// state  | meaning
// S_OFF  | display dark, cnt/idx held at 0, waits for EN
// S_LOAD | capture HEX_IN/DP_IN into shadow, restart at digit 0
// S_SCAN | cnt counts slot cycles, idx selects digit, reload at frame end
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int PRESCALE  = 1024,
    parameter int BLANK_CYC = 4,
    parameter bit LZ_BLANK  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic [4*N_DIGITS-1:0] HEX_IN,
    input  logic [N_DIGITS-1:0]   DP_IN,
    output logic [6:0]            SEG_N,
    output logic                  DP_N,
    output logic [N_DIGITS-1:0]   AN_N,
    output logic                  FRAME_DONE
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow;
    logic [N_DIGITS-1:0]   dp_shadow;

    logic                  slot_end;
    logic                  frame_end;
    logic                  lz_hide;
    logic                  shown;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg_n;

    logic [6:0]            seg_n_nxt;
    logic                  dp_n_nxt;
    logic [N_DIGITS-1:0]   an_n_nxt;
    logic                  frame_done_nxt;

    assign slot_end   = (cnt == CNT_MAX);
    // Frame only completes while still enabled; a disable mid-frame abandons it.
    assign frame_end  = (state == S_SCAN) && EN && slot_end && (idx == IDX_MAX);
    assign cur_nibble = shadow[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .NIBBLE (cur_nibble),
        .SEG_N  (cur_seg_n)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_OFF:   state_nxt = EN ? S_LOAD : S_OFF;
            S_LOAD:  state_nxt = EN ? S_SCAN : S_OFF;
            S_SCAN:  state_nxt = EN ? S_SCAN : S_OFF;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Slot counter, digit index and shadow value registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt       <= '0;
            idx       <= '0;
            shadow    <= '0;
            dp_shadow <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    cnt       <= '0;
                    idx       <= '0;
                    shadow    <= HEX_IN;
                    dp_shadow <= DP_IN;
                end
                S_SCAN: begin
                    if (!EN) begin
                        cnt <= '0;
                        idx <= '0;
                    end else if (slot_end) begin
                        cnt <= '0;
                        if (idx == IDX_MAX) begin
                            idx       <= '0;
                            shadow    <= HEX_IN;
                            dp_shadow <= DP_IN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                    idx <= '0;
                end
            endcase
        end
    end

    // Leading-zero suppression: digit idx (>0) hides when it and all higher nibbles are zero.
    always_comb begin
        lz_hide = 1'b0;
        if (LZ_BLANK && (idx != '0)) begin
            lz_hide = ((shadow >> {idx, 2'b00}) == '0);
        end
    end

    // Output decode from current state; registered below for one-cycle latency.
    always_comb begin
        shown          = (state == S_SCAN) && (cnt >= CNT_BLANK) && !lz_hide;
        an_n_nxt       = {N_DIGITS{AN_OFF}};
        seg_n_nxt      = SEG_OFF;
        dp_n_nxt       = 1'b1;
        frame_done_nxt = frame_end;
        if (shown) begin
            an_n_nxt  = ~(N_DIGITS'(1) << idx);
            seg_n_nxt = cur_seg_n;
            dp_n_nxt  = ~dp_shadow[idx];
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            AN_N       <= {N_DIGITS{AN_OFF}};
            SEG_N      <= SEG_OFF;
            DP_N       <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            AN_N       <= an_n_nxt;
            SEG_N      <= seg_n_nxt;
            DP_N       <= dp_n_nxt;
            FRAME_DONE <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: two instances (leading-zero blanking off/on)
// share stimulus and are compared each cycle against a frame-position model.
module tb_sevenseg_scan_driver;

    localparam int N  = 8;
    localparam int P  = 4;
    localparam int B  = 1;
    localparam int NP = N * P;

    localparam int PH_OFF  = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_SCAN = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        EN;
    logic [31:0] HEX_IN;
    logic [7:0]  DP_IN;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [7:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fd  = -1;
    bit track    = 1'b0;

    // Model: phase, position within the frame, displayed value.
    int          m_phase = PH_LOAD;
    int          m_pos   = 0;
    logic [31:0] m_val   = '0;
    logic [7:0]  m_dp    = '0;
    bit          m_valid = 1'b0;

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 CLK = ~CLK;

    sevenseg_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B), .LZ_BLANK(1'b0)) u_dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .HEX_IN(HEX_IN), .DP_IN(DP_IN),
        .SEG_N(seg_a), .DP_N(dp_a), .AN_N(an_a), .FRAME_DONE(fd_a)
    );

    sevenseg_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B), .LZ_BLANK(1'b1)) u_dut_lz (
        .CLK(CLK), .RESET(RESET), .EN(EN), .HEX_IN(HEX_IN), .DP_IN(DP_IN),
        .SEG_N(seg_b), .DP_N(dp_b), .AN_N(an_b), .FRAME_DONE(fd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Expected {AN_N, SEG_N, DP_N} from the model's frame position.
    function automatic logic [15:0] ref_disp(input bit lz);
        int          d;
        int          o;
        logic [31:0] upper;
        logic [3:0]  nib;
        logic [7:0]  an;
        bit          show;
        if (m_phase != PH_SCAN) return {8'hFF, 7'h7F, 1'b1};
        d     = m_pos / P;
        o     = m_pos % P;
        upper = m_val >> (4 * d);
        nib   = upper[3:0];
        show  = (o >= B) && !(lz && (d > 0) && (upper == 0));
        if (!show) return {8'hFF, 7'h7F, 1'b1};
        an = ~(8'd1 << d);
        return {an, seg_ref[nib], ~m_dp[d]};
    endfunction

    task automatic step();
        logic [15:0] e0, e1;
        logic        ef;
        @(posedge CLK);
        if (RESET) begin
            e0      = {8'hFF, 7'h7F, 1'b1};
            e1      = e0;
            ef      = 1'b0;
            m_phase = PH_LOAD;
            m_pos   = 0;
            m_val   = '0;
            m_dp    = '0;
            m_valid = 1'b1;
        end else begin
            e0 = ref_disp(1'b0);
            e1 = ref_disp(1'b1);
            ef = (m_phase == PH_SCAN) && EN && (m_pos == NP - 1);
            case (m_phase)
                PH_OFF:  if (EN) m_phase = PH_LOAD;
                PH_LOAD: begin
                    m_val   = HEX_IN;
                    m_dp    = DP_IN;
                    m_pos   = 0;
                    m_phase = EN ? PH_SCAN : PH_OFF;
                end
                default: begin
                    if (!EN) begin
                        m_phase = PH_OFF;
                        m_pos   = 0;
                    end else if (m_pos == NP - 1) begin
                        m_pos = 0;
                        m_val = HEX_IN;
                        m_dp  = DP_IN;
                    end else begin
                        m_pos++;
                    end
                end
            endcase
        end
        @(negedge CLK);
        cyc++;
        if (m_valid) begin
            check_eq("an",     {24'd0, an_a},  {24'd0, e0[15:8]});
            check_eq("seg",    {25'd0, seg_a}, {25'd0, e0[7:1]});
            check_eq("dp",     {31'd0, dp_a},  {31'd0, e0[0]});
            check_eq("fd",     {31'd0, fd_a},  {31'd0, ef});
            check_eq("an_lz",  {24'd0, an_b},  {24'd0, e1[15:8]});
            check_eq("seg_lz", {25'd0, seg_b}, {25'd0, e1[7:1]});
            check_eq("dp_lz",  {31'd0, dp_b},  {31'd0, e1[0]});
            check_eq("fd_lz",  {31'd0, fd_b},  {31'd0, ef});
        end
        if (track && fd_a === 1'b1) begin
            if (last_fd >= 0) check_eq("fd_period", cyc - last_fd, NP);
            last_fd = cyc;
        end
    endtask

    initial begin
        RESET  = 1'b1;
        EN     = 1'b0;
        HEX_IN = '0;
        DP_IN  = '0;
        repeat (2) step();
        RESET = 1'b0;
        repeat (3) step();

        EN     = 1'b1;
        HEX_IN = 32'h12345678;
        track  = 1'b1;
        repeat (80) step();
        HEX_IN = 32'hDEADBEEF;
        repeat (70) step();
        track  = 1'b0;
        check_eq("fd_seen", {31'd0, last_fd >= 0}, 32'd1);

        HEX_IN = 32'h00000A05;
        repeat (70) step();
        HEX_IN = 32'h0;
        repeat (70) step();

        HEX_IN = 32'h87654321;
        DP_IN  = 8'h04;
        repeat (70) step();

        repeat (5) step();
        EN = 1'b0;
        repeat (10) step();
        EN = 1'b1;
        repeat (40) step();

        repeat (3) step();
        RESET  = 1'b1;
        HEX_IN = 32'hCAFE0123;
        step();
        RESET = 1'b0;
        repeat (40) step();

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(39, 0) == 0) EN = ~EN;
            if ($urandom_range(7, 0) == 0) begin
                HEX_IN = $urandom;
                if ($urandom_range(1, 0) == 0) HEX_IN = HEX_IN >> (4 * $urandom_range(7, 0));
            end
            if ($urandom_range(7, 0) == 0) DP_IN = 8'($urandom);
            RESET = ($urandom_range(99, 0) == 0);
            step();
        end
        RESET = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
